im_fifo_rd_ctrl: RTL and testbench
==================================

# im_fifo_rd_ctrl

Read-side sequencer for the image-mode FIFO. It waits until the FIFO reports a complete frame (full), then drains exactly one frame of 32-bit words through a 2-entry output buffer onto an AXI-Stream master with SOF/EOF framing, throttling FIFO reads against downstream backpressure. It also owns the FIFO flush pulse for software aborts. It sits between the FIFO's `ready_to_read`/`start_to_read`/`rdata_to_user` ports and the packetizer.

## Interface
Parameters:
- `FRAME_WORDS`, 256: words per frame; equals FIFO depth.
- `FLUSH_CYCLES`, 4: width of the `fifo_flush` pulse in cycles (≥1).
- `CNT_W`, 16: width of the status counters.

Ports:
- `clk`  in  1  single clock for the block and the FIFO.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits a new frame to start; sampled only in IDLE.
- `flush_req`  in  1  single-cycle software abort/flush request.
- `fifo_full`  in  1  FIFO full flag (`ready_to_read`).
- `fifo_rdata`  in  32  FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO read strobe (`start_to_read`).
- `fifo_flush`  out  1  FIFO synchronous flush (`arst_for_imfifo`).
- `m_tdata`  out  32  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  high on word `FRAME_WORDS-1` of the frame.
- `m_tuser`  out  1  SOF, high on word 0 of the frame.
- `busy`  out  1  high in every state except IDLE.
- `frame_cnt`  out  CNT_W  number of completed frames; wraps.
- `abort_cnt`  out  CNT_W  number of frames aborted by flush; wraps.

## Operation
- States: IDLE, READ, DRAIN, FLUSH.
- Reset values:
  - Outputs: all outputs 0.
  - Internal: buffer empty, in-flight 0, counters 0, state IDLE.
- IDLE:
  - `enable && fifo_full` → READ.
  - Load the remaining-read counter with `FRAME_WORDS` and the word index with 0.
- READ:
  - `fifo_rd_en = (rem != 0) && (occ + inflight - pop < 2)`, where `occ` is buffer occupancy (0–2), `inflight` is the registered previous `fifo_rd_en`, and `pop = m_tvalid && m_tready`.
  - Each `fifo_rd_en` decrements `rem`.
  - When `rem` reaches 0 → DRAIN.
- Data path:
  - The word returned the cycle after `fifo_rd_en` is written into the 2-entry FIFO-ordered buffer.
  - `m_tdata`/`m_tvalid` present the buffer head.
  - A word index counts handshakes: `m_tuser = (idx==0)`, `m_tlast = (idx==FRAME_WORDS-1)`.
  - Data is in-order and lossless.
- DRAIN:
  - No reads.
  - On the `m_tlast` handshake: `frame_cnt++`, then → IDLE.
- FLUSH:
  - Entered from any state when `flush_req` is sampled high.
  - `fifo_flush` is high for exactly `FLUSH_CYCLES` cycles, starting the cycle after `flush_req`.
  - The buffer is cleared and any in-flight word is discarded.
  - `m_tvalid` = 0 throughout; no `m_tlast` is emitted for the aborted frame.
  - When the pulse ends → IDLE.
  - `flush_req` is ignored while in FLUSH.
- `abort_cnt++` when `flush_req` is accepted in READ or DRAIN and that cycle is not an `m_tlast` handshake.
- Simultaneous flush and `m_tlast` handshake:
  - The frame is counted in `frame_cnt`, not in `abort_cnt`.
  - The block still enters FLUSH.
- `enable` deasserted mid-frame has no effect; the current frame completes.
- `fifo_full` is ignored outside IDLE. Writes continuing into the FIFO during READ are the next frame's data.
- Once stable, `m_tvalid`/`m_tdata` must not drop or change while `m_tready` is low, except on flush.

## Timing
- `fifo_full` sampled high in IDLE at edge 0 → READ in cycle 1; first `fifo_rd_en` in cycle 1.
- First `m_tvalid` in cycle 3: data returns in cycle 2 and is registered into the buffer.
- With `m_tready` held high, `fifo_rd_en` is high for `FRAME_WORDS` consecutive cycles (1..N) and `m_tvalid` for N consecutive cycles (3..N+2).
- Last handshake in cycle N+2; IDLE in cycle N+3.
- Earliest next-frame start: `fifo_full` sampled at the end of cycle N+3.
- Backpressure: after `m_tready` falls, at most 2 words are outstanding (buffer plus in-flight); reads resume the cycle `m_tready` returns.
- `flush_req` high in cycle t:
  - `fifo_rd_en` = 0 from t+1.
  - `m_tvalid` = 0 from t+1.
  - `fifo_flush` high in t+1..t+FLUSH_CYCLES.
  - IDLE in t+FLUSH_CYCLES+1.

## Test plan
- **Nominal frame:** `FRAME_WORDS=8`, FIFO preloaded 0..7, `m_tready=1`, `enable=1` → `fifo_rd_en` high in cycles 1–8; stream 0..7 in cycles 3–10; `m_tuser` on word 0; `m_tlast` on word 7; `frame_cnt=1`.
- **Backpressure:** `m_tready` toggles 1,0,0,1 repeating → all 8 words in order, no loss or duplication; `occ+inflight` never exceeds 2; data stable while stalled.
- **Abort:** `flush_req` after 3 handshakes → `fifo_flush` high exactly 4 cycles; no `m_tlast`; `abort_cnt=1`; `frame_cnt=0`; the next full FIFO yields a clean frame with `m_tuser` on its first word.
- **Simultaneous events:** `flush_req` in the same cycle as the `m_tlast` handshake → `frame_cnt=1`, `abort_cnt=0`, `fifo_flush` pulse still issued.
- **Gating and reset:**
  - `enable=0` with FIFO full → no reads.
  - `enable` dropped mid-frame → frame completes.
  - `rst` mid-READ → all outputs 0 next cycle; counters cleared.
- **Back-to-back and wrap:** 3 full frames back-to-back → `frame_cnt=3`. With `CNT_W=2`, 5 frames → `frame_cnt` wraps to 1.

Source files
------------

// File: rtl/im_fifo_rd_ctrl.sv
// Read-side sequencer for the image-mode FIFO: drains one full frame through a
// 2-entry buffer onto an AXI-Stream master with SOF/EOF framing and flush control.
module im_fifo_rd_ctrl #(
    parameter int unsigned FRAME_WORDS  = 256,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flush_req,
    input  logic             fifo_full,
    input  logic [31:0]      fifo_rdata,
    output logic             fifo_rd_en,
    output logic             fifo_flush,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam int unsigned IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned REM_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       buf0_q, buf0_d;
    logic [31:0]       buf1_q, buf1_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  abort_cnt_q, abort_cnt_d;

    logic              valid_c;
    logic              pop_c;
    logic              last_hs_c;
    logic              flush_acc_c;
    logic [2:0]        lvl_c;
    logic              rd_en_c;

    // Handshake and read-throttle decode; lvl_c is what the buffer will hold after this edge
    always_comb begin
        valid_c     = (occ_q != 2'd0);
        pop_c       = valid_c && m_tready;
        last_hs_c   = pop_c && (idx_q == LAST_IDX);
        flush_acc_c = flush_req && (state_q != ST_FLUSH);
        lvl_c       = 3'(occ_q) + 3'(inflight_q) - 3'(pop_c);
        rd_en_c     = (state_q == ST_READ) && (rem_q != REM_W'(0)) && (lvl_c < 3'd2);
    end

    // Next-state, buffer and counter logic
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        occ_d       = occ_q;
        inflight_d  = rd_en_c;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        fcnt_d      = fcnt_q;
        frame_cnt_d = frame_cnt_q;
        abort_cnt_d = abort_cnt_q;

        if (pop_c) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (last_hs_c) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        // Buffer entry 0 is always the head presented on the stream
        case ({inflight_q, pop_c})
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rdata;
                end else begin
                    buf0_d = fifo_rdata;
                end
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_rdata;
                end else begin
                    buf1_d = fifo_rdata;
                end
                occ_d = occ_q + 2'd1;
            end
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                rem_d = REM_W'(FRAME_WORDS);
                idx_d = '0;
                if (enable && fifo_full) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_en_c) begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_hs_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == FC_W'(0)) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completing frame on the same edge as a flush still counts as completed
        if (flush_acc_c) begin
            state_d    = ST_FLUSH;
            fcnt_d     = FC_W'(FLUSH_CYCLES - 1);
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            if (((state_q == ST_READ) || (state_q == ST_DRAIN)) && !last_hs_c) begin
                abort_cnt_d = abort_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            idx_q       <= '0;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            fcnt_q      <= '0;
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            fcnt_q      <= fcnt_d;
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign fifo_rd_en = rd_en_c;
    assign fifo_flush = (state_q == ST_FLUSH);
    assign busy       = (state_q != ST_IDLE);
    assign m_tvalid   = valid_c;
    assign m_tdata    = buf0_q;
    assign m_tuser    = valid_c && (idx_q == '0);
    assign m_tlast    = valid_c && (idx_q == LAST_IDX);
    assign frame_cnt  = frame_cnt_q;
    assign abort_cnt  = abort_cnt_q;

endmodule

// File: tb/tb_im_fifo_rd_ctrl.sv
// Directed bench for im_fifo_rd_ctrl: 8-word frames, 4-cycle flush, 2-bit counters.
module tb_im_fifo_rd_ctrl;

    localparam int unsigned FW = 8;
    localparam int unsigned FC = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        flush_req;
    logic        fifo_full;
    logic [31:0] fifo_rdata;
    logic        fifo_rd_en;
    logic        fifo_flush;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic        busy;
    logic [1:0]  frame_cnt;
    logic [1:0]  abort_cnt;

    int          total;
    int          bad;
    logic [31:0] base;
    logic [2:0]  rptr;

    im_fifo_rd_ctrl #(.FRAME_WORDS(FW), .FLUSH_CYCLES(FC), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush_req(flush_req),
        .fifo_full(fifo_full), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
        .fifo_flush(fifo_flush), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy),
        .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: a preloaded frame base+0..7, emptied by flush or reset
    always @(posedge clk) begin
        if (rst || fifo_flush) begin
            rptr       <= 3'd0;
            fifo_rdata <= 32'd0;
        end else if (fifo_rd_en) begin
            fifo_rdata <= base + 32'(rptr);
            rptr       <= rptr + 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input logic [1:0] exp_fc, input logic [1:0] exp_ac);
        @(negedge clk);
        fifo_full = 1'b0;
        flush_req = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_frame_cnt", frame_cnt, exp_fc);
        chk("idle_abort_cnt", abort_cnt, exp_ac);
    endtask

    // One frame from IDLE; flush_hs>=0 raises flush_req once that many handshakes are done
    task automatic run_frame(input logic [31:0] b, input bit bp, input int flush_hs,
                             input bit drop_en, input bit keep_full,
                             input logic [1:0] exp_fc, input logic [1:0] exp_ac);
        int          k;
        int          reads;
        int          pops;
        int          fl_cnt;
        bit          fl_seen;
        bit          fl_now;
        bit          done;
        bit          pv;
        bit          pr;
        logic [31:0] pd;
        k = 0; reads = 0; pops = 0; fl_cnt = 0;
        fl_seen = 1'b0; done = 1'b0; pv = 1'b0; pr = 1'b0; pd = 32'd0;
        base = b;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            fl_now    = (flush_hs >= 0) && !fl_seen && (k == flush_hs) && (cyc > 0);
            flush_req = fl_now;
            fifo_full = !fl_seen && ((cyc == 0) || keep_full);
            enable    = !(drop_en && cyc >= 2);
            m_tready  = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (cyc == 0) begin
                chk("start_busy", busy, 0);
                chk("start_rd_en", fifo_rd_en, 0);
                chk("start_tvalid", m_tvalid, 0);
                chk("start_flush", fifo_flush, 0);
                chk("start_frame_cnt", frame_cnt, exp_fc);
                chk("start_abort_cnt", abort_cnt, exp_ac);
            end else if (fl_seen) begin
                chk("flush_tvalid", m_tvalid, 0);
                chk("flush_rd_en", fifo_rd_en, 0);
                if (busy) begin
                    chk("flush_pulse", fifo_flush, 1);
                    fl_cnt++;
                end else begin
                    chk("flush_len", fl_cnt, FC);
                    chk("flush_end", fifo_flush, 0);
                    done = 1'b1;
                end
            end else begin
                if (!bp) begin
                    chk("rd_en_timing", fifo_rd_en, (cyc >= 1) && (cyc <= 8));
                    chk("tvalid_timing", m_tvalid, (cyc >= 3) && (cyc <= 10));
                end
                if (pv && !pr) begin
                    chk("stall_valid", m_tvalid, 1);
                    chk("stall_data", m_tdata, pd);
                end
                chk("outstanding_le2", (reads - pops) <= 2, 1);
                if (m_tvalid && m_tready) begin
                    chk("data", m_tdata, b + 32'(k));
                    chk("tuser", m_tuser, k == 0);
                    chk("tlast", m_tlast, k == FW - 1);
                    k++;
                    pops++;
                end
                if (fifo_rd_en) reads++;
                if (k == FW && !fl_now) begin
                    chk("read_total", reads, FW);
                    done = 1'b1;
                end
            end
            pv = m_tvalid;
            pr = m_tready;
            pd = m_tdata;
            if (fl_now) fl_seen = 1'b1;
        end
        flush_req = 1'b0;
        chk("frame_timeout", done, 1);
    endtask

    initial begin
        total = 0; bad = 0; base = 32'd0;
        rst = 1'b1; enable = 1'b0; flush_req = 1'b0; fifo_full = 1'b0; m_tready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_flush", fifo_flush, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tuser", m_tuser, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_abort_cnt", abort_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // enable low with a full FIFO: nothing starts
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            enable = 1'b0;
            fifo_full = 1'b1;
            #1;
            chk("gate_rd_en", fifo_rd_en, 0);
            chk("gate_busy", busy, 0);
        end

        // Nominal, backpressure, enable dropped mid-frame
        run_frame(32'h1000_0000, 1'b0, -1, 1'b0, 1'b0, 2'd0, 2'd0);
        run_frame(32'h2000_0000, 1'b1, -1, 1'b0, 1'b0, 2'd1, 2'd0);
        run_frame(32'h3000_0000, 1'b0, -1, 1'b1, 1'b0, 2'd2, 2'd0);
        idle_check(2'd3, 2'd0);

        // Synchronous reset in the middle of READ
        @(negedge clk);
        enable = 1'b1;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            fifo_full = 1'b0;
        end
        #1;
        chk("pre_rst_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_rd_en", fifo_rd_en, 0);
        chk("midrst_tvalid", m_tvalid, 0);
        chk("midrst_tdata", m_tdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_abort_cnt", abort_cnt, 0);

        // Abort after 3 handshakes, then a clean frame, then flush on the tlast handshake
        run_frame(32'h4000_0000, 1'b0, 3, 1'b0, 1'b0, 2'd0, 2'd0);
        run_frame(32'h5000_0000, 1'b0, -1, 1'b0, 1'b0, 2'd0, 2'd1);
        run_frame(32'h6000_0000, 1'b0, FW - 1, 1'b0, 1'b0, 2'd1, 2'd1);
        idle_check(2'd2, 2'd1);

        // Five back-to-back frames; the 2-bit frame counter wraps
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 5; f++) begin
            run_frame(32'h7000_0000 + 32'(f) * 32'h100, 1'b0, -1, 1'b0, 1'b1,
                      2'(f), 2'd0);
        end
        idle_check(2'd1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
